// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and defaults for the instruction fetch unit
package instruction_fetch_pkg;

    localparam int          ADDR_W_DEF     = 32;
    localparam int          DATA_W_DEF     = 32;
    localparam int          IMEM_DEPTH_DEF = 5;
    localparam logic [31:0] RESET_PC_DEF   = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry circular {pc, instr} FIFO with flush
module fetch_buffer #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [PC_W-1:0]   i_push_pc,
    input  logic [DATA_W-1:0] i_push_instr,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [1:0]        o_count,
    output logic              o_empty,
    output logic [PC_W-1:0]   o_head_pc,
    output logic [DATA_W-1:0] o_head_instr
);

    logic [PC_W-1:0]   r_pc    [2];
    logic [DATA_W-1:0] r_instr [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;

    logic w_pop;
    logic w_push;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc[r_wr_ptr]    <= i_push_pc;
                r_instr[r_wr_ptr] <= i_push_instr;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_empty      = (r_count == 2'd0);
    assign o_head_pc    = r_pc[r_rd_ptr];
    assign o_head_instr = r_instr[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, fetch FSM and credit control feeding decode through a 2-entry buffer
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fault,
    output logic              busy
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_fault;

    logic       w_issue;
    logic       w_fault_set;
    logic       w_in_range;
    logic       w_pop;
    logic       w_push;
    logic       w_empty;
    logic [1:0] w_count;
    logic [2:0] w_credit_use;
    logic       w_credit_ok;

    assign w_in_range   = (r_fetch_pc < ADDR_W'(IMEM_DEPTH));
    assign w_pop        = inst_valid & inst_ready;
    assign w_push       = r_inflight & ~redirect_valid;
    // Slots already claimed after this cycle's pop; a new issue needs one free slot.
    assign w_credit_use = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit_ok  = (w_credit_use < 3'd2);

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_fault_set  = 1'b0;
        if (redirect_valid) begin
            w_state_next = enable ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) w_state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!w_in_range) begin
                        w_state_next = ST_FAULT;
                        w_fault_set  = 1'b1;
                    end else if (!enable) begin
                        w_state_next = ST_IDLE;
                    end else if (w_credit_ok) begin
                        w_issue = 1'b1;
                    end
                end
                ST_FAULT: w_state_next = ST_FAULT;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_fault       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_inflight <= 1'b0;
                r_fault    <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_pc <= r_fetch_pc;
                    r_fetch_pc    <= r_fetch_pc + 1'b1;
                end
                if (w_fault_set) r_fault <= 1'b1;
            end
        end
    end

    fetch_buffer #(
        .PC_W   (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_pc    (r_inflight_pc),
        .i_push_instr (imem_instr),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_count      (w_count),
        .o_empty      (w_empty),
        .o_head_pc    (inst_pc),
        .o_head_instr (inst_out)
    );

    // The fetch PC register itself drives the memory address, so it is always the next word to read.
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = ~w_empty;
    assign fault      = r_fault;
    assign busy       = (r_state == ST_RUN) | ~w_empty | r_inflight;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Initiator side of the instruction-memory interface: owns the program counter, drives the word address to the synchronous-read instruction memory and captures the returned word one cycle later.
- Delivers {pc, instruction} pairs to decode over a valid/ready handshake.
- A 2-entry buffer absorbs the in-flight read whenever decode stalls.
- Supports branch/jump redirect with squash of in-flight data, and faults on out-of-range fetch.

Parameters:
- ADDR_W, 32, width of PC and memory address (word index, not byte address)
- DATA_W, 32, instruction width
- IMEM_DEPTH, 5, number of valid memory words; addresses >= IMEM_DEPTH are out of range
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  fetch start/continue; 0 suppresses new issues
- imem_addr  output  ADDR_W  word address to instruction memory, registered
- imem_instr  input  DATA_W  memory read data, valid the cycle after the address edge
- redirect_valid  input  1  single-cycle branch/jump request
- redirect_pc  input  ADDR_W  redirect target word address
- inst_valid  output  1  buffer head holds a valid instruction
- inst_ready  input  1  decode accepts head this cycle
- inst_out  output  DATA_W  head instruction
- inst_pc  output  ADDR_W  word address of inst_out
- fault  output  1  sticky; set when fetch_pc is out of range
- busy  output  1  1 in state RUN or while buffer/in-flight non-empty

Behaviour:
- Reset (asynchronous, rst_n=0): fetch_pc=RESET_PC, imem_addr=RESET_PC, state=IDLE, buffer empty, inflight=0, inst_valid=0, inst_out=0, inst_pc=0, fault=0, busy=0.
- Memory timing: imem_addr presented during cycle N is sampled at edge N. imem_instr is valid during cycle N+1 and is captured into the buffer at edge N+1 when inflight=1. Fetch-to-buffer latency is 1 edge; buffer-to-output latency is 0, since inst_out/inst_pc come combinationally from the head entry.
- Issue condition: state=RUN, enable=1, redirect_valid=0, fetch_pc<IMEM_DEPTH, and (occupancy + inflight - pop) < 2, where pop = inst_valid & inst_ready.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (wraps modulo 2^ADDR_W), imem_addr follows the new fetch_pc.
  - With no issue: inflight<=0 once the pending word is captured; imem_addr holds.
- Buffer: 2-entry circular FIFO of {pc, instr}. Push and pop in the same cycle are both performed; occupancy is unchanged. Push never occurs when full, which is guaranteed by the credit rule. Sustained throughput with inst_ready=1 is 1 instruction per cycle.
- Redirect (redirect_valid=1 at an edge): flush buffer, clear inflight, drop that cycle's returning word, set fetch_pc=imem_addr=redirect_pc, clear fault, state=RUN if enable else IDLE. No issue occurs in the redirect cycle; the first issue of the target is at the next edge. Redirect has priority over every other event, including a simultaneous pop. The popped instruction in that cycle still counts as accepted by decode.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0. The in-flight word is still captured and the buffer still drains; fetch_pc is held.
  - RUN -> FAULT when fetch_pc>=IMEM_DEPTH at an edge with no redirect. fault<=1 and no issue occurs. Buffered and in-flight valid words still drain.
  - FAULT -> RUN/IDLE only on redirect to any pc; a redirect to an out-of-range pc re-enters FAULT next edge.
- Reset mid-operation: all state clears immediately. The in-flight memory word is ignored because inflight=0 after reset.
- Boundary rule: fetch_pc = IMEM_DEPTH-1 is fetched normally; fault asserts at the following edge.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, FAULT=2'd2), RESET_PC, IMEM_DEPTH default, ADDR_W/DATA_W.
- One sub-module: fetch_buffer, the 2-entry {pc, instr} FIFO with push/pop/flush, count, and head outputs.
- PC/FSM/credit logic stays in instruction_fetch.
- The bench instantiates it against the existing instruction memory loaded from Instruction.txt.

Test Plan:
- Streaming: memory words 0..4 = 0xA0..0xA4, enable=1, inst_ready=1 held. Required response:
  - inst_valid first rises 2 cycles after enable.
  - Words are delivered as (pc, inst) = (0,0xA0), (1,0xA1), ..., (4,0xA4) on consecutive cycles.
  - fault=1 the cycle after pc 4 issues; inst_valid drops after (4,0xA4).
- Backpressure: inst_ready=0 from cycle 3 to 8. Required response:
  - Buffer fills to 2 and imem_addr freezes.
  - On inst_ready=1, (0,0xA0), (1,0xA1), (2,0xA2) follow in order with no loss or duplicates.
- Redirect mid-stream: redirect_valid=1, redirect_pc=3 while pc 1 is in flight. Required response:
  - 0xA1 is never presented.
  - The next delivered pair is (3,0xA3), two cycles after the redirect edge.
- Simultaneous push/pop/redirect: buffer full, inst_ready=1, redirect to pc 0 in the same cycle. Required response:
  - The head is popped once.
  - The buffer is empty next cycle, then (0,0xA0) is delivered.
- Fault recovery: run past pc 4 so fault=1, then redirect to pc 2. Required response:
  - fault clears at the redirect edge and (2,0xA2) is delivered.
  - A redirect to pc 7 sets fault again with no delivery.
- Async reset: drop rst_n mid-stream, between clock edges. Required response:
  - inst_valid=0, imem_addr=0, fault=0 immediately.
  - After release with enable=1, the stream restarts at (0,0xA0).
